// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB requester.
package apb_pkg;

    localparam int unsigned AWIDTH_DEF = 8;
    localparam int unsigned DWIDTH_DEF = 32;

    // Bus-side phase of the requester; 2'b11 is unused and falls back to IDLE.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_e;

    // Command as presented by system-side logic at the default widths.
    typedef struct packed {
        logic                  write;
        logic [AWIDTH_DEF-1:0] addr;
        logic [DWIDTH_DEF-1:0] wdata;
    } apb_cmd_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter; expire flags the last allowed ACCESS cycle.
module apb_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned CW        = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned LIMIT_INT = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CW-1:0] LIMIT   = LIMIT_INT[CW-1:0];

    logic [CW-1:0] count;

    // Count stalled ACCESS cycles, holding at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + CW'(1);
        end
    end

    // TIMEOUT of 0 means wait forever.
    assign expire = (TIMEOUT != 0) && (count == LIMIT);

endmodule

// File: rtl/apb_master.sv
// APB requester: turns valid/ready commands into SETUP/ACCESS transfers
// and returns one response pulse per command.
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned AWIDTH  = AWIDTH_DEF,
    parameter int unsigned DWIDTH  = DWIDTH_DEF,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [DWIDTH-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              p_sel,
    output logic              p_en,
    output logic              p_write,
    output logic [AWIDTH-1:0] addr,
    output logic [DWIDTH-1:0] wdata,
    input  logic [DWIDTH-1:0] rdata,
    input  logic              p_ready
);

    apb_state_e        state, state_nxt;
    logic              p_sel_nxt, p_en_nxt, p_write_nxt;
    logic [AWIDTH-1:0] addr_nxt;
    logic [DWIDTH-1:0] wdata_nxt, rsp_rdata_nxt;
    logic              rsp_valid_nxt, rsp_err_nxt;
    logic              tmr_clr, tmr_en, tmr_expire;

    apb_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .expire(tmr_expire)
    );

    // Ready depends only on state so a consumer can't form a loop through cmd_valid.
    assign cmd_ready = (state == IDLE) && !rst;

    // Next-state and bus/response outputs; bus fields hold unless a command is taken.
    always_comb begin
        state_nxt     = state;
        p_sel_nxt     = p_sel;
        p_en_nxt      = p_en;
        p_write_nxt   = p_write;
        addr_nxt      = addr;
        wdata_nxt     = wdata;
        rsp_valid_nxt = 1'b0;
        rsp_err_nxt   = 1'b0;
        rsp_rdata_nxt = rsp_rdata;
        tmr_clr       = 1'b0;
        tmr_en        = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    p_write_nxt = cmd_write;
                    addr_nxt    = cmd_addr;
                    wdata_nxt   = cmd_wdata;
                    p_sel_nxt   = 1'b1;
                    p_en_nxt    = 1'b0;
                    state_nxt   = SETUP;
                end
            end
            SETUP: begin
                p_en_nxt  = 1'b1;
                tmr_clr   = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                if (p_ready) begin
                    p_sel_nxt     = 1'b0;
                    p_en_nxt      = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_rdata_nxt = p_write ? '0 : rdata;
                    state_nxt     = IDLE;
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_expire) begin
                        p_sel_nxt     = 1'b0;
                        p_en_nxt      = 1'b0;
                        rsp_valid_nxt = 1'b1;
                        rsp_err_nxt   = 1'b1;
                        rsp_rdata_nxt = '0;
                        state_nxt     = IDLE;
                    end
                end
            end
            default: begin
                p_sel_nxt = 1'b0;
                p_en_nxt  = 1'b0;
                tmr_clr   = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops the bus immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            p_sel     <= 1'b0;
            p_en      <= 1'b0;
            p_write   <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_nxt;
            p_sel     <= p_sel_nxt;
            p_en      <= p_en_nxt;
            p_write   <= p_write_nxt;
            addr      <= addr_nxt;
            wdata     <= wdata_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_err   <= rsp_err_nxt;
            rsp_rdata <= rsp_rdata_nxt;
        end
    end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester that drives the APB slave bus (`p_sel`/`p_en`/`p_write`/`addr`/`wdata`, with `rdata`/`p_ready` returned).
- Converts a simple valid/ready command interface into compliant SETUP→ACCESS transfers.
- Returns one response per command, with read data or an error flag.
- Sits between the system-side register/DMA logic and the APB slave; in the APB environment it replaces the hand-driven bench stimulus.

Parameters:
- AWIDTH, 8, APB address width
- DWIDTH, 32, APB data width
- TIMEOUT, 16, max ACCESS cycles waiting for `p_ready` before abort; 0 disables timeout

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  AWIDTH  transfer address
- cmd_wdata  in  DWIDTH  write data (ignored for reads)
- rsp_valid  out  1  one-cycle pulse: transfer finished
- rsp_rdata  out  DWIDTH  read data (0 for writes and errors)
- rsp_err  out  1  qualifies rsp_valid: transfer timed out
- p_sel  out  1  APB select
- p_en  out  1  APB enable
- p_write  out  1  APB direction
- addr  out  AWIDTH  APB address
- wdata  out  DWIDTH  APB write data
- rdata  in  DWIDTH  APB read data
- p_ready  in  1  APB slave ready

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - p_sel, p_en, p_write, rsp_valid, rsp_err = 0.
  - addr, wdata, rsp_rdata = 0.
  - Timeout counter = 0.
- States (2-bit): IDLE=00, SETUP=01, ACCESS=10; encoding 11 is illegal and recovers to IDLE.
- cmd_ready = (state==IDLE) && !rst. It is combinational from state only, never from cmd_valid.
- IDLE:
  - Handshake when cmd_valid && cmd_ready at a posedge.
  - At that edge, register cmd_write/cmd_addr/cmd_wdata into p_write/addr/wdata, set p_sel=1, p_en=0, go to SETUP.
- SETUP (exactly 1 cycle):
  - Next edge: p_en=1, go to ACCESS, clear timeout counter.
  - p_ready is ignored in SETUP.
- ACCESS, on an edge where p_ready=1:
  - Clear p_sel and p_en; go to IDLE.
  - Pulse rsp_valid for 1 cycle with rsp_err=0.
  - Read: rsp_rdata = rdata sampled at that same edge. Write: rsp_rdata = 0.
- ACCESS, on an edge where p_ready=0:
  - Counter increments.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 on that edge: abort.
  - Abort: p_sel=p_en=0, IDLE, rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - Counter width is $clog2(TIMEOUT+1), saturating; no wrap.
- Stability:
  - addr, wdata and p_write are constant from SETUP entry through ACCESS exit.
  - After completion they hold their last values while p_sel=0.
- Latency and throughput:
  - Accept at edge N → SETUP visible N..N+1, ACCESS from N+1.
  - Zero-wait slave: rsp_valid high during cycle after edge N+2.
  - Minimum 3 cycles per transfer; cmd_ready is high again in the cycle rsp_valid is high, so back-to-back accept is allowed in that cycle.
- rsp_valid has no back-pressure; the consumer must take it.
- Outside ACCESS: p_ready and rdata are ignored.
- Reset mid-transfer: bus is dropped immediately, no response is produced, and the in-flight command is lost.
- The block does not decode address range; any address is forwarded.

Decomposition:
- Package apb_pkg:
  - AWIDTH/DWIDTH default localparams.
  - Typedef enum logic[1:0] apb_state_e {IDLE, SETUP, ACCESS}.
  - Typedef struct apb_cmd_t {write, addr, wdata}.
- Sub-module apb_wait_timer: saturating counter with clear/enable/expire, parameterised by TIMEOUT. The FSM stays in apb_master.

Test Plan:
- Reset: rst=1 mid-ACCESS (write addr 5) → next sample shows p_sel=p_en=0, cmd_ready=0 while rst held, no rsp_valid; after rst=0, cmd_ready=1.
- Single write, zero-wait slave: cmd write addr=23 wdata=55 → SETUP cycle p_sel=1 p_en=0 addr=23 wdata=55, ACCESS cycle p_en=1, rsp_valid pulse err=0 rdata=0, exactly 3 cycles accept→rsp.
- Write then read back: writes addr i, wdata 2*i for i=0..9, then reads addr 0..9 → rsp_rdata = 0,2,4..18, err=0, each read response matching its address.
- Wait states: slave holds p_ready=0 for 3 ACCESS cycles on read addr 23 (data 55) → p_en stays 1, addr stable, rsp_valid 1 cycle after p_ready rises, rdata=55.
- Timeout: TIMEOUT=16, p_ready stuck 0 → abort after 16 ACCESS cycles, rsp_valid=1 rsp_err=1 rsp_rdata=0, p_sel=0; next command accepted normally.
- Back-to-back: cmd_valid held high with 4 commands → new SETUP starts the cycle after each rsp_valid, cmd_ready never high outside IDLE, p_ready=1 during SETUP ignored.
